// File: rtl/iso14443_2a_tx.sv
// ISO/IEC 14443-2 Type A PICC->PCD transmitter.
// Encodes a bit stream into Manchester-coded subcarrier load modulation.
// The frame is SOF (sequence D), one bit period per data bit (D for 1,
// E for 0) and EOF (sequence F, no modulation).
//
// Bit handshake with the frame encoder: in_data_valid/in_data are sampled
// only in IDLE and on the last cycle of each bit period (the boundary).
// A boundary that sees in_data_valid=1 consumes in_data. in_req pulses
// for one cycle right after that boundary, telling the encoder to present
// its next bit (or to drop in_data_valid) before the following boundary.
// A boundary that sees in_data_valid=0 ends the frame with EOF.
module iso14443_2a_tx #(
    parameter int SC_HALF = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_data,
    input  logic       in_data_valid,
    output logic       in_req,
    output logic       lm_out,
    output logic       busy,
    output logic       done,
    output logic [1:0] fsm_state
);

    localparam int BIT_PERIOD = 16 * SC_HALF;
    localparam int CW         = $clog2(BIT_PERIOD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SOF  = 2'd1,
        DATA = 2'd2,
        EOF  = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          cur_bit;
    logic          boundary;
    logic          sc_on;
    logic          first_half;
    logic          pattern;

    assign fsm_state = state;
    assign boundary  = (cnt == CW'(BIT_PERIOD - 1));

    // Modulation pattern for the current state, position and latched bit.
    always_comb begin
        sc_on      = (int'(cnt) % (2 * SC_HALF)) < SC_HALF;
        first_half = int'(cnt) < (BIT_PERIOD / 2);
        pattern    = 1'b0;
        case (state)
            SOF:     pattern = first_half & sc_on;
            DATA:    pattern = cur_bit ? (first_half & sc_on)
                                       : (~first_half & sc_on);
            default: pattern = 1'b0;
        endcase
    end

    // Frame sequencer with bit-period counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            cur_bit <= 1'b0;
            lm_out  <= 1'b0;
            in_req  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            in_req <= 1'b0;
            done   <= 1'b0;
            lm_out <= pattern;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (in_data_valid) begin
                        state <= SOF;
                        busy  <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                SOF, DATA: begin
                    cnt <= boundary ? '0 : cnt + 1'b1;
                    if (boundary) begin
                        if (in_data_valid) begin
                            cur_bit <= in_data;
                            in_req  <= 1'b1;
                            state   <= DATA;
                        end else begin
                            state   <= EOF;
                        end
                    end
                end
                EOF: begin
                    cnt <= boundary ? '0 : cnt + 1'b1;
                    if (boundary) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
